// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared types and helpers for the AXI4-Lite register file.
//   resp_t    - AXI response codes
//   rstate_t  - read channel state
//   addr_lsb  - number of byte-offset address bits for a given bus width
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_READ = 2'b01,
    R_RESP = 2'b10
  } rstate_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/byte_write_ram.sv
// byte_write_ram: simple dual-port word RAM, one clock.
//   Write port: per-byte enables we, word address waddr, data wdata.
//   Read port : re/raddr, registered rdata one cycle later.
//   A read and a write to the same word on the same edge return the old word.
//   Contents are not reset.
module byte_write_ram #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave over a byte-writable register file.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   aw*/w*/b*                  - write address / data / response channels
//   ar*/r*                     - read address / data channels
//   wr_en/wr_idx/wr_data/wr_strb - registered one-cycle notification of each
//                                committed in-range write
// Build option: AXI4_LITE_REGFILE_PROT_EN - when defined, accesses with
//   prot[0]=0 are rejected like out-of-window accesses (SLVERR, no effect).
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter  int                    DATA_WIDTH = 32,
  parameter  int                    DEPTH      = 256,
  parameter  int                    ADDR_WIDTH = 32,
  parameter  logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                    STRB_W     = DATA_WIDTH / 8,
  localparam int                    IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_W-1:0]     wr_strb
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("axi4_lite_regfile: DATA_WIDTH must be 32 or 64");
  end

  localparam int                  LSB    = addr_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] SPAN   = (ADDR_WIDTH+1)'(DEPTH * STRB_W);
  localparam logic [ADDR_WIDTH:0] BASE_X = {1'b0, BASE_ADDR};

  // One extra bit so BASE_ADDR + window size cannot wrap.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ax;
    ax = {1'b0, a};
    return (ax >= BASE_X) && (ax < BASE_X + SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LSB);
  endfunction

  logic aw_priv, ar_priv;
`ifdef AXI4_LITE_REGFILE_PROT_EN
  assign aw_priv = awprot[0];
  assign ar_priv = arprot[0];
`else
  logic prot_unused;
  assign prot_unused = ^{awprot, arprot};
  assign aw_priv     = 1'b1;
  assign ar_priv     = 1'b1;
`endif

  // ---------------- write path ----------------
  logic                  aw_full, w_full, aw_ok;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  resp_t                 bresp_q;
  logic                  aw_hs, w_hs, commit, commit_wr;

  assign awready   = rst_n && !aw_full;
  assign wready    = rst_n && !w_full;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  // A new commit waits until the previous response has been taken.
  assign commit    = aw_full && w_full && !bvalid;
  assign commit_wr = commit && aw_ok;
  assign bresp     = bresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bresp_q <= OKAY;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      aw_full <= !commit && (aw_full || aw_hs);
      w_full  <= !commit && (w_full || w_hs);
      if (commit) begin
        bvalid  <= 1'b1;
        bresp_q <= aw_ok ? OKAY : SLVERR;
      end else if (bvalid && bready) begin
        bvalid  <= 1'b0;
      end
      wr_en <= commit_wr;
      if (commit_wr) begin
        wr_idx  <= aw_idx;
        wr_data <= w_data;
        wr_strb <= w_strb;
      end
    end
  end

  // Holding registers: only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_idx <= addr_idx(awaddr);
      aw_ok  <= addr_hit(awaddr) && aw_priv;
    end
    if (w_hs) begin
      w_data <= wdata;
      w_strb <= wstrb;
    end
  end

  // ---------------- read path ----------------
  rstate_t               state, state_nxt;
  logic                  ar_hs, vld_p0, vld_p1, rd_ok_p0;
  logic [IDX_W-1:0]      rd_idx_p0;
  logic [DATA_WIDTH-1:0] ram_q;
  resp_t                 rresp_q;

  assign arready = rst_n && (state == R_IDLE);
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (state == R_RESP);
  assign rresp   = rresp_q;

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (arvalid) state_nxt = R_READ;
      R_READ:  if (vld_p1)  state_nxt = R_RESP;
      R_RESP:  if (rready)  state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      rdata   <= '0;
      rresp_q <= OKAY;
    end else begin
      state  <= state_nxt;
      // p0: address captured -> p1: RAM word available -> response registered
      vld_p0 <= ar_hs;
      vld_p1 <= vld_p0;
      if (vld_p1) begin
        rdata   <= rd_ok_p0 ? ram_q : '0;
        rresp_q <= rd_ok_p0 ? OKAY : SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_idx_p0 <= addr_idx(araddr);
      rd_ok_p0  <= addr_hit(araddr) && ar_priv;
    end
  end

  byte_write_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (commit_wr ? w_strb : '0),
    .waddr(aw_idx),
    .wdata(w_data),
    .re   (vld_p0 && rd_ok_p0),
    .raddr(rd_idx_p0),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Testbench for axi4_lite_regfile (DATA_WIDTH=32, DEPTH=256, BASE_ADDR=0).
module tb_axi4_lite_regfile;

  localparam int DEPTH = 256;
`ifdef AXI4_LITE_REGFILE_PROT_EN
  localparam bit PROT_CHK = 1'b1;
`else
  localparam bit PROT_CHK = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, wr_data;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0, wr_strb;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, wr_en;
  logic [1:0]  bresp, rresp;
  logic [7:0]  wr_idx;

  always #5 clk = ~clk;

  axi4_lite_regfile #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  int total = 0, bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_ok(logic [31:0] a, logic [2:0] p);
    return (a < 32'h400) && (p[0] || !PROT_CHK);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];
  bit          m_aw_full, m_w_full, m_bv, m_wr_en, m_rbusy, m_rv;
  logic [31:0] m_aw_addr, m_w_data, m_wr_data, m_rdata, m_rmask, m_raddr;
  logic [2:0]  m_aw_prot, m_rprot;
  logic [3:0]  m_w_strb, m_wr_strb;
  logic [1:0]  m_bresp, m_rresp;
  logic [7:0]  m_wr_idx;
  int          m_rage;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 4'h0;

  always @(negedge clk) begin : monitor
    bit commit, aw_acc, w_acc, ar_acc, bv_pre;
    int ix;
    if (!rst_n) begin
      chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);   chk("rst_wr_en", wr_en, 0);
      chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);     chk("rst_wr_idx", wr_idx, 0);
      chk("rst_wr_data", wr_data, 0); chk("rst_wr_strb", wr_strb, 0);
      m_aw_full = 0; m_w_full = 0; m_bv = 0; m_wr_en = 0;
      m_rbusy = 0; m_rv = 0; m_rage = 0;
    end else begin
      chk("awready", awready, !m_aw_full);
      chk("wready", wready, !m_w_full);
      chk("bvalid", bvalid, m_bv);
      if (m_bv) chk("bresp", bresp, m_bresp);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("wr_idx", wr_idx, m_wr_idx);
        chk("wr_data", wr_data, m_wr_data);
        chk("wr_strb", wr_strb, m_wr_strb);
      end
      chk("arready", arready, !m_rbusy);
      chk("rvalid", rvalid, m_rv);
      if (m_rv) begin
        chk("rresp", rresp, m_rresp);
        chk("rdata", rdata & m_rmask, m_rdata & m_rmask);
      end
      // read side first: a read sampling memory on the same edge as a write sees old data
      ar_acc = !m_rbusy && arvalid;
      if (m_rbusy) begin
        if (m_rv) begin
          if (rready) begin m_rv = 0; m_rbusy = 0; end
        end else begin
          m_rage++;
          if (m_rage == 1) begin
            if (m_ok(m_raddr, m_rprot)) begin
              ix = int'(m_raddr[9:2]);
              m_rdata = m_mem[ix];
              for (int b = 0; b < 4; b++) m_rmask[b*8 +: 8] = {8{m_known[ix][b]}};
              m_rresp = 2'b00;
            end else begin
              m_rdata = '0; m_rmask = '1; m_rresp = 2'b10;
            end
          end
          if (m_rage == 2) m_rv = 1;
        end
      end
      if (ar_acc) begin m_rbusy = 1; m_rage = 0; m_raddr = araddr; m_rprot = arprot; end
      // write side
      bv_pre = m_bv;
      commit = m_aw_full && m_w_full && !bv_pre;
      aw_acc = !m_aw_full && awvalid;
      w_acc  = !m_w_full && wvalid;
      m_wr_en = 0;
      if (bv_pre && bready) m_bv = 0;
      if (commit) begin
        m_bv = 1; m_aw_full = 0; m_w_full = 0;
        if (m_ok(m_aw_addr, m_aw_prot)) begin
          ix = int'(m_aw_addr[9:2]);
          for (int b = 0; b < 4; b++) if (m_w_strb[b]) begin
            m_mem[ix][b*8 +: 8] = m_w_data[b*8 +: 8];
            m_known[ix][b] = 1'b1;
          end
          m_bresp = 2'b00; m_wr_en = 1;
          m_wr_idx = 8'(ix); m_wr_data = m_w_data; m_wr_strb = m_w_strb;
        end else begin
          m_bresp = 2'b10;
        end
      end
      if (aw_acc) begin m_aw_full = 1; m_aw_addr = awaddr; m_aw_prot = awprot; end
      if (w_acc)  begin m_w_full = 1; m_w_data = wdata; m_w_strb = wstrb; end
    end
  end

  int   wr_cnt = 0;
  logic [7:0] last_wr_idx = '0;
  always @(negedge clk) if (rst_n && wr_en) begin wr_cnt++; last_wr_idx = wr_idx; end

  // ---------------- bus tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] resp);
    int c, blat;
    bit awd, wd, aw_now, w_now;
    c = 0; awd = 0; wd = 0;
    awaddr = a; awprot = p; wdata = d; wstrb = s;
    while (!(awd && wd)) begin
      if (!awd && c >= aw_dly) awvalid = 1;
      if (!wd && c >= w_dly) wvalid = 1;
      @(negedge clk);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_now) begin awvalid = 0; awd = 1; end
      if (w_now)  begin wvalid = 0; wd = 1; end
      c++;
      if (c > 50) begin
        awvalid = 0; wvalid = 0; resp = 2'b11;
        chk("write_accepted", 0, 1);
        return;
      end
    end
    blat = 0;
    do begin @(negedge clk); blat++; end while (!bvalid && blat < 20);
    chk("b_latency", blat, 2);
    resp = bresp;
    repeat (b_dly) @(posedge clk);
    @(posedge clk); #1; bready = 1;
    @(negedge clk);
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int r_dly,
                         output logic [31:0] d, output logic [1:0] resp);
    int c, lat;
    bit hs;
    araddr = a; arprot = p; arvalid = 1; c = 0; hs = 0;
    while (!hs && c <= 50) begin
      @(negedge clk); hs = arvalid && arready;
      @(posedge clk); #1; c++;
    end
    arvalid = 0;
    if (!hs) begin chk("read_accepted", 0, 1); d = '0; resp = 2'b11; return; end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 20);
    chk("r_latency", lat, 3);
    d = rdata; resp = rresp;
    repeat (r_dly) begin
      @(posedge clk); #1; @(negedge clk);
      chk("rhold_rdata", rdata, d);
      chk("rhold_arready", arready, 0);
    end
    @(posedge clk); #1; rready = 1;
    @(negedge clk);
    @(posedge clk); #1; rready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    if (r == 7) return 32'($urandom_range(0, 1023));
    return 32'h400 + 32'($urandom_range(0, 65535));
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run still active at time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          cnt0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_awready", awready, 0); chk("reset_arready", arready, 0);
    chk("reset_bvalid", bvalid, 0);   chk("reset_rvalid", rvalid, 0);
    @(posedge clk); #1; rst_n = 1;

    // AW held without W, then reset mid-transaction
    awaddr = 32'h20; awprot = 3'b001; awvalid = 1;
    @(posedge clk); #1; awvalid = 0;
    @(negedge clk); chk("aw_held_awready", awready, 0);
    @(posedge clk); #1; rst_n = 0;
    @(negedge clk);
    chk("midrst_awready", awready, 0); chk("midrst_wready", wready, 0);
    chk("midrst_arready", arready, 0); chk("midrst_bvalid", bvalid, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk); chk("postrst_awready", awready, 1);
    @(posedge clk); #1;
    do_write(32'h10, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0, 0, r);
    chk("a5_bresp", r, 2'b00);
    do_read(32'h10, 3'b001, 0, d, r);
    chk("a5_rdata", d, 32'hA5A5A5A5); chk("a5_rresp", r, 2'b00);

    // partial strobe, W leads AW by 3 cycles
    do_write(32'h8, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0, 0, r);
    cnt0 = wr_cnt;
    do_write(32'h8, 32'h12345678, 4'b0011, 3'b001, 3, 0, 0, r);
    chk("strb_bresp", r, 2'b00);
    chk("strb_wr_pulses", wr_cnt - cnt0, 1);
    chk("strb_wr_idx", last_wr_idx, 8'd2);
    do_read(32'h8, 3'b001, 0, d, r);
    chk("strb_rdata", d, 32'hFFFF5678);

    // out of window
    cnt0 = wr_cnt;
    do_write(32'h400, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0, r);
    chk("oor_bresp", r, 2'b10);
    chk("oor_no_wr_en", wr_cnt - cnt0, 0);
    do_read(32'h400, 3'b001, 0, d, r);
    chk("oor_rdata", d, 0); chk("oor_rresp", r, 2'b10);

    // bready held low while a second write is queued behind the response
    awaddr = 32'h20; awprot = 3'b001; awvalid = 1; wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    awaddr = 32'h800; awvalid = 1; wdata = 32'h0BAD0BAD; wvalid = 1;
    @(negedge clk);
    chk("b2_awready_pending", awready, 1); chk("b2_wready_pending", wready, 1);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    repeat (5) begin
      @(negedge clk); chk("bhold_bvalid", bvalid, 1); chk("bhold_bresp", bresp, 2'b00);
    end
    @(posedge clk); #1; bready = 1;
    @(negedge clk); chk("b1_before_hs", bvalid, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("b2_gap_bvalid", bvalid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2_bvalid", bvalid, 1); chk("b2_bresp", bresp, 2'b10);
    @(posedge clk); #1; bready = 0;

    // rready held low for 4 cycles
    do_read(32'h20, 3'b001, 4, d, r);
    chk("rhold_value", d, 32'hCAFE0001); chk("rhold_rresp", r, 2'b00);
    @(negedge clk); chk("ar_ready_after_hs", arready, 1);
    @(posedge clk); #1;

`ifdef AXI4_LITE_REGFILE_PROT_EN
    do_write(32'h0, 32'h600DF00D, 4'hF, 3'b001, 0, 0, 0, r);
    chk("prot_priv_bresp", r, 2'b00);
    do_read(32'h0, 3'b000, 0, d, r);
    chk("prot_unpriv_rdata", d, 0); chk("prot_unpriv_rresp", r, 2'b10);
    do_read(32'h0, 3'b001, 0, d, r);
    chk("prot_priv_rdata", d, 32'h600DF00D); chk("prot_priv_rresp", r, 2'b00);
    do_write(32'h0, 32'h11111111, 4'hF, 3'b000, 0, 0, 0, r);
    chk("prot_unpriv_bresp", r, 2'b10);
`endif

    // randomized concurrent traffic, checked by the model
    fork
      begin
        logic [1:0] wr_r;
        repeat (150)
          do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wr_r);
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        repeat (150)
          do_read(rand_addr(), 3'($urandom_range(0, 7)), $urandom_range(0, 3), rd_d, rd_r);
      end
    join

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave backed by a byte-writable register file, the generational successor to the single-width lstm control slave. Accepts AW and W independently with one-entry holding registers, applies write strobes, decodes a configurable address window and returns SLVERR outside it. Exposes a registered write-event port so datapath blocks (LSTM weight/bias loaders) can snoop committed writes.

## Interface
- DATA_WIDTH, 32: bus and word width; 32 or 64 only.
- DEPTH, 256: number of words; power of two, ≥2.
- ADDR_WIDTH, 32: AXI address width.
- BASE_ADDR, 0: byte base of the window; aligned to DEPTH*DATA_WIDTH/8.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  write response.
- araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- wr_en  out  1  one-cycle pulse per committed in-range write.
- wr_idx  out  $clog2(DEPTH)  word index of committed write.
- wr_data/wr_strb  out  DATA_WIDTH/DATA_WIDTH/8  data and strobe of committed write.

## Operation
- Address decode: byte address; LSB = $clog2(DATA_WIDTH/8); low LSB bits ignored. In range iff BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*DATA_WIDTH/8; idx = (addr − BASE_ADDR) >> LSB.
- Write path: aw_full/w_full hold flags. awready = rst_n && !aw_full; wready = rst_n && !w_full. Commit when aw_full && w_full && !bvalid: clear both flags, set bvalid, bresp = OKAY (2'b00) in range else SLVERR (2'b10). In-range commit writes only bytes with wstrb[i]=1 and pulses wr_en; out-of-range writes nothing, no wr_en.
- bvalid/bresp held until bready; new AW/W may be captured while bvalid is pending, next commit waits for bready handshake.
- Read FSM: R_IDLE → (arvalid) R_READ → R_RESP → (rready) R_IDLE. arready = rst_n && state==R_IDLE. rdata/rresp registered, stable throughout R_RESP. Out of range: rdata = 0, rresp = SLVERR, no RAM read.
- Same-cycle commit and RAM read to same word: read-first (old data returned).
- Reset (any time, async): awready/wready/arready/bvalid/rvalid/wr_en = 0, bresp/rresp = 0, rdata = 0, wr_idx/wr_data/wr_strb = 0, hold flags cleared, FSM → R_IDLE; in-flight transactions discarded. Storage contents not reset.

## Timing
- Write: AW and W both handshaken by edge N → commit and bvalid=1 after edge N+1; wr_en high for the cycle following edge N+1. AW at N, W at M → commit after max(N,M)+1.
- Write throughput: one per 2 cycles with bready tied high.
- Read: AR at edge N → rvalid=1 after edge N+2; arready low from after N until rvalid&&rready handshake; next AR earliest the cycle after.
- Read and write channels fully independent; no ordering between them.

## Configuration
- AXI4_LITE_REGFILE_PROT_EN defined: accesses with prot[0]=0 (unprivileged) are treated as out of range → SLVERR, no write, rdata 0.
- Undefined: awprot/arprot ignored, privilege not checked.

## Structure
- axi4_lite_pkg: resp_t enum (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11), read FSM state typedef, addr_lsb() function.
- One sub-module byte_write_ram: simple dual-port, one clock, DATA_WIDTH/8 byte write enables, 1-cycle registered read, read-first.

## Test plan
- Reset mid-write (AW held, W not): rst_n low 1 cycle → all valids/readies 0; after release write 0xA5A5A5A5 to 0x10, read 0x10 → 0xA5A5A5A5, OKAY.
- W 3 cycles before AW to 0x8, wstrb=0b0011 over 0xFFFFFFFF, wdata 0x12345678 → readback 0xFFFF5678; bvalid 1 cycle after AW accept; wr_en one pulse, wr_idx=2.
- Write 0x400 with DEPTH=256, DATA_WIDTH=32 → bresp SLVERR, no wr_en; read 0x400 → rdata 0, rresp SLVERR.
- bready held low 5 cycles: bvalid/bresp stable; second AW/W accepted, its bvalid only after first handshake.
- rready low 4 cycles after AR: rdata stable, arready low; AR accepted the cycle after handshake; AR at N gives rvalid at N+2.
- PROT_EN build: read 0x0 with arprot=3'b000 → SLVERR, rdata 0; arprot=3'b001 → OKAY with stored data.
